vector_issue_controller: RTL and testbench

//  Sequences the 4-stage vector pipeline (VID, VRR, VEXE, VWB): buffers vector instructions from the scalar front end
//  in a small FIFO and issues at most one per cycle into the IF/VID latch. Tracks in-flight vd writes and inserts a

---
 rtl/vector_issue_controller_pkg.sv | 33 +++
 rtl/vector_scoreboard.sv | 44 ++++
 rtl/vector_issue_controller.sv | 94 +++++++++
 tb/tb_vector_issue_controller.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/vector_issue_controller_pkg.sv
// vector_issue_controller_pkg: VNOP encoding, field positions and register-use decode for the vector issue path.
package vector_issue_controller_pkg;
  localparam logic [31:0] VNOP_INSTR = 32'h0000_0013;
  localparam logic [6:0] OP_V = 7'b1010111;
  localparam logic [6:0] OP_VL = 7'b0000111;
  localparam logic [6:0] OP_VS = 7'b0100111;
  typedef struct packed {
    logic rd_vs1;
    logic rd_vs2;
    logic rd_vd;
    logic wr_vd;
  } reg_use_t;
  function automatic logic [4:0] f_vd(input logic [31:0] i);
    return i[11:7];
  endfunction
  function automatic logic [4:0] f_vs1(input logic [31:0] i);
    return i[19:15];
  endfunction
  function automatic logic [4:0] f_vs2(input logic [31:0] i);
    return i[24:20];
  endfunction
  // OPIVV/OPFVV/OPMVV read vs1; the vmacc/vmadd family and stores also read vd/vs3
  function automatic reg_use_t decode_use(input logic [31:0] i);
    logic opv;
    reg_use_t u;
    opv = i[6:0] == OP_V && i[14:12] != 3'b111;
    u.rd_vs1 = opv && i[14:12] < 3'd3;
    u.rd_vs2 = opv;
    u.rd_vd = (opv && i[14:12] == 3'b010 && i[31:29] == 3'b101 && i[26]) || i[6:0] == OP_VS;
    u.wr_vd = opv || i[6:0] == OP_VL;
    return u;
  endfunction
endpackage

// File: rtl/vector_scoreboard.sv
// vector_scoreboard: in-flight {valid,vd,wr} shift register for VID/VRR/VEXE with RAW hazard compare.
module vector_scoreboard
  import vector_issue_controller_pkg::*;
#(
  parameter int PIPE_SLOTS = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       shift_i,
  input  logic       clear_i,
  input  logic       ins_valid_i,
  input  logic [4:0] ins_vd_i,
  input  logic       ins_wr_i,
  input  logic [4:0] vs1_i,
  input  logic [4:0] vs2_i,
  input  logic [4:0] vd_i,
  input  reg_use_t   use_i,
  output logic       hazard_o,
  output logic       any_valid_o
);
  logic [PIPE_SLOTS-1:0] valid, wr;
  logic [PIPE_SLOTS-1:0][4:0] vd;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      valid <= '0;
      wr <= '0;
      vd <= '0;
    end else if (clear_i) begin
      valid <= '0;
    end else if (shift_i) begin
      valid <= {valid[PIPE_SLOTS-2:0], ins_valid_i};
      wr <= {wr[PIPE_SLOTS-2:0], ins_wr_i};
      vd <= {vd[PIPE_SLOTS-2:0], ins_vd_i};
    end
  // slot 0 source matches are covered by the VWB->VEXE forward path
  always_comb begin
    hazard_o = 1'b0;
    for (int s = 0; s < PIPE_SLOTS; s++)
      if (valid[s] && wr[s])
        hazard_o |= (use_i.rd_vd && vd_i == vd[s]) ||
                    (s != 0 && ((use_i.rd_vs1 && vs1_i == vd[s]) || (use_i.rd_vs2 && vs2_i == vd[s])));
  end
  assign any_valid_o = |valid;
endmodule

// File: rtl/vector_issue_controller.sv
// vector_issue_controller: issue FIFO, hazard-gated single issue into IF/VID, load/flush control.
// Optional VEC_ISSUE_PERF_EN adds saturating issued/bubble counters.
module vector_issue_controller
  import vector_issue_controller_pkg::*;
#(
  parameter int INSTRUCTION_LENGTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int PIPE_SLOTS = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          stall_i,
  input  logic                          instr_valid_i,
  output logic                          instr_ready_o,
  input  logic [INSTRUCTION_LENGTH-1:0] instr_i,
  input  logic [2:0]                    vsew_i,
  output logic [INSTRUCTION_LENGTH-1:0] instruction_o,
  output logic [2:0]                    vsew_o,
  output logic                          load_o,
  output logic                          flush_o,
  output logic                          busy_o
`ifdef VEC_ISSUE_PERF_EN
  ,
  output logic [31:0]                   issued_cnt_o,
  output logic [31:0]                   bubble_cnt_o
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [INSTRUCTION_LENGTH-1:0] mem_instr [FIFO_DEPTH];
  logic [2:0] mem_vsew [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic [INSTRUCTION_LENGTH-1:0] head;
  reg_use_t head_use;
  logic head_valid, hazard, any_slot, enq, advance, issue;
  assign head = mem_instr[rptr];
  assign head_valid = count != '0;
  assign head_use = decode_use(head[31:0]);
  assign instr_ready_o = count != (AW+1)'(FIFO_DEPTH) && !flush_i;
  assign enq = instr_valid_i && instr_ready_o;
  assign flush_o = flush_i;
  assign load_o = !stall_i || flush_i;
  assign advance = !stall_i && !flush_i;
  assign issue = advance && head_valid && !hazard;
  assign instruction_o = issue ? head : INSTRUCTION_LENGTH'(VNOP_INSTR);
  assign vsew_o = issue ? mem_vsew[rptr] : 3'd0;
  assign busy_o = head_valid || any_slot;
  always_ff @(posedge clk_i)
    if (enq) begin
      mem_instr[wptr] <= instr_i;
      mem_vsew[wptr] <= vsew_i;
    end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (flush_i) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= enq ? wptr + 1'b1 : wptr;
      rptr <= issue ? rptr + 1'b1 : rptr;
      count <= count + (AW+1)'(enq) - (AW+1)'(issue);
    end
  vector_scoreboard #(.PIPE_SLOTS(PIPE_SLOTS)) u_scoreboard (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .shift_i     (advance),
    .clear_i     (flush_i),
    .ins_valid_i (issue),
    .ins_vd_i    (f_vd(head[31:0])),
    .ins_wr_i    (head_use.wr_vd),
    .vs1_i       (f_vs1(head[31:0])),
    .vs2_i       (f_vs2(head[31:0])),
    .vd_i        (f_vd(head[31:0])),
    .use_i       (head_use),
    .hazard_o    (hazard),
    .any_valid_o (any_slot)
  );
`ifdef VEC_ISSUE_PERF_EN
  // empty-queue bubbles are not hazards and are not counted
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      issued_cnt_o <= '0;
      bubble_cnt_o <= '0;
    end else begin
      issued_cnt_o <= issue && issued_cnt_o != '1 ? issued_cnt_o + 1'b1 : issued_cnt_o;
      bubble_cnt_o <= advance && head_valid && hazard && bubble_cnt_o != '1 ? bubble_cnt_o + 1'b1 : bubble_cnt_o;
    end
`endif
endmodule

// File: tb/tb_vector_issue_controller.sv
// tb_vector_issue_controller: randomized and directed stimulus against a queue-based issue model.
module tb_vector_issue_controller;
  localparam logic [31:0] VNOP = 32'h0000_0013;
  localparam int DEPTH = 4;
  localparam int SLOTS = 3;
  typedef struct {
    logic [31:0] instr;
    logic [2:0] vsew;
    logic [4:0] vd, vs1, vs2;
    bit rv1, rv2, rvd, wr;
  } ent_t;
  typedef struct {
    logic [4:0] vd;
    bit wr;
    int age;
  } fly_t;
  logic clk_i = 0, rst_i = 1, flush_i = 0, stall_i = 0, instr_valid_i = 0;
  logic [31:0] instr_i = '0;
  logic [2:0] vsew_i = '0;
  logic instr_ready_o, load_o, flush_o, busy_o;
  logic [31:0] instruction_o;
  logic [2:0] vsew_o;
  int vectors = 0, errors = 0;
  ent_t q[$];
  fly_t fly[$];
  vector_issue_controller dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
    .vsew_i(vsew_i), .instruction_o(instruction_o), .vsew_o(vsew_o),
    .load_o(load_o), .flush_o(flush_o), .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  // kinds: 0 vadd.vv, 1 vadd.vx, 2 vmacc.vv, 3 vse, 4 vle, 5 scalar addi
  function automatic ent_t mk(input int k, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b, input logic [2:0] s);
    ent_t e;
    e.vd = d; e.vs1 = a; e.vs2 = b; e.vsew = s;
    e.rv1 = k == 0 || k == 2;
    e.rv2 = k <= 2;
    e.rvd = k == 2 || k == 3;
    e.wr = k <= 2 || k == 4;
    case (k)
      0: e.instr = {6'b000000, 1'b1, b, a, 3'b000, d, 7'b1010111};
      1: e.instr = {6'b000000, 1'b1, b, a, 3'b100, d, 7'b1010111};
      2: e.instr = {6'b101101, 1'b1, b, a, 3'b010, d, 7'b1010111};
      3: e.instr = {7'b0000001, 5'd0, a, 3'b000, d, 7'b0100111};
      4: e.instr = {7'b0000001, 5'd0, a, 3'b000, d, 7'b0000111};
      default: e.instr = {12'd0, a, 3'b000, d, 7'b0010011};
    endcase
    return e;
  endfunction
  // the youngest in-flight writer is reachable by forwarding for vs1/vs2 only
  function automatic bit blocked(input ent_t e);
    foreach (fly[j])
      if (fly[j].wr && ((e.rvd && e.vd == fly[j].vd) ||
          (fly[j].age > 0 && ((e.rv1 && e.vs1 == fly[j].vd) || (e.rv2 && e.vs2 == fly[j].vd)))))
        return 1;
    return 0;
  endfunction
  task automatic step(input bit v, input ent_t e, input bit st, input bit fl);
    bit rdy, can;
    fly_t n;
    @(negedge clk_i);
    instr_valid_i = v; instr_i = e.instr; vsew_i = e.vsew; stall_i = st; flush_i = fl;
    #1;
    rdy = !fl && q.size() < DEPTH;
    can = !fl && !st && q.size() > 0 && !blocked(q[0]);
    check("instr", instruction_o, can ? q[0].instr : VNOP);
    check("vsew", {29'd0, vsew_o}, can ? {29'd0, q[0].vsew} : 32'd0);
    check("load", {31'd0, load_o}, {31'd0, !st || fl});
    check("flush", {31'd0, flush_o}, {31'd0, fl});
    check("ready", {31'd0, instr_ready_o}, {31'd0, rdy});
    check("busy", {31'd0, busy_o}, {31'd0, q.size() > 0 || fly.size() > 0});
    if (fl) begin
      q.delete();
      fly.delete();
    end else begin
      if (!st) begin
        for (int j = fly.size() - 1; j >= 0; j--) begin
          fly[j].age++;
          if (fly[j].age >= SLOTS) fly.delete(j);
        end
        if (can) begin
          n.vd = q[0].vd; n.wr = q[0].wr; n.age = 0;
          fly.push_back(n);
          void'(q.pop_front());
        end
      end
      if (v && rdy) q.push_back(e);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, mk(5, 0, 0, 0, 0), 0, 0);
  endtask
  task automatic reset_check();
    @(negedge clk_i);
    instr_valid_i = 0; stall_i = 0; flush_i = 0; rst_i = 1;
    #1;
    q.delete();
    fly.delete();
    check("rst_instr", instruction_o, VNOP);
    check("rst_vsew", {29'd0, vsew_o}, 32'd0);
    check("rst_load", {31'd0, load_o}, 32'd1);
    check("rst_flush", {31'd0, flush_o}, 32'd0);
    check("rst_ready", {31'd0, instr_ready_o}, 32'd1);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 0;
  endtask
  initial begin
    reset_check();
    // independent back-to-back, then busy drain
    step(1, mk(0, 1, 2, 3, 3'd2), 0, 0);
    step(1, mk(0, 4, 5, 6, 3'd1), 0, 0);
    idle(6);
    // slot0 forward: no bubble
    step(1, mk(0, 1, 2, 3, 0), 0, 0);
    step(1, mk(0, 4, 1, 5, 0), 0, 0);
    idle(6);
    // slot1 conflict: two bubbles
    step(1, mk(0, 1, 2, 3, 0), 0, 0);
    step(1, mk(0, 7, 8, 9, 0), 0, 0);
    step(1, mk(0, 4, 1, 5, 0), 0, 0);
    idle(8);
    // vd_read on MAC: three bubbles
    step(1, mk(2, 1, 2, 3, 0), 0, 0);
    step(1, mk(2, 1, 4, 5, 0), 0, 0);
    idle(8);
    // fill under stall, then drain
    for (int i = 0; i < 6; i++) step(1, mk(0, 5'(10 + i), 5'(20 + i), 5'(25 + i), 3'(i)), 1, 0);
    idle(10);
    // flush with queued and in-flight work
    for (int i = 0; i < 5; i++) step(1, mk(0, 5'(i), 5'(i + 8), 5'(i + 16), 0), i < 1, 0);
    step(1, mk(0, 1, 1, 1, 0), 0, 1);
    idle(3);
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0,
           mk($urandom_range(0, 5), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 3'($urandom_range(0, 7))),
           $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0);
      if (i == 700) reset_check();
    end
    idle(6);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
